rf_loader: RTL and testbench
============================

# rf_loader

Load/compute sequencer that sits directly upstream of the register file (RF) and drives its `RF_EN`, `WRITE`, `IDX` and 16 data lanes. It accepts one matrix row per valid/ready beat: 8 input-matrix (X) lanes and 8 pre-transposed weight (W) lanes. It writes `ROWS` rows into the RF, then steps `IDX` through the skewed compute sweep that feeds the systolic array. It waits out the array drain latency and then signals completion.

## Interface
Parameters:
- `DW`, default 16: lane width in bits.
- `ROWS`, default 8: rows loaded per job, and lanes per matrix.
- `COMPUTE_STEPS`, default 15 (2*ROWS-1): number of IDX steps in the compute sweep.
- `DRAIN_CYCLES`, default 8: idle cycles after the sweep before DONE.

Ports:
- `CLK` in 1: clock. One clock domain.
- `RSTN` in 1: reset, asynchronous and active-low.
- `START` in 1: job request. Sampled only in IDLE.
- `ABORT` in 1: synchronous cancel. Valid in any state.
- `IN_VALID` in 1: row beat valid.
- `IN_READY` out 1: loader can accept a row.
- `IN_X` in ROWS*DW: X row. Lane k is at bits [k*DW +: DW].
- `IN_W` in ROWS*DW: W row, same lane layout as `IN_X`.
- `RF_EN` out 1: RF enable.
- `WRITE` out 1: 1 = load, 0 = compute.
- `IDX` out 5: RF row index.
- `X_DATA` out ROWS*DW: X lanes; lane k drives `DATA_IN_k`.
- `W_DATA` out ROWS*DW: W lanes; lane k drives `DATA_IN_(8+k)`.
- `BUSY` out 1: high in any state other than IDLE.
- `DONE` out 1: one-cycle completion pulse.

## Operation
- States are IDLE, LOAD, COMPUTE, DRAIN and FINISH.
- All outputs except `IN_READY` are registered.
- `IN_READY` = (state == LOAD). It is combinational from the state register.
- IDLE:
  - All outputs are 0.
  - `START` moves the FSM to LOAD and clears the row counter.
- LOAD:
  - Each handshake (`IN_VALID && IN_READY`) registers `IN_X`/`IN_W` into `X_DATA`/`W_DATA`, sets `IDX` = row counter, `WRITE`=1 and `RF_EN`=1 for the next cycle, and increments the row counter.
  - A cycle with no handshake gives `RF_EN`=0 next cycle. `WRITE`, `IDX` and the data lanes hold their values.
  - The handshake that loads row `ROWS-1` moves the FSM to COMPUTE.
- COMPUTE:
  - For step c = 0..`COMPUTE_STEPS`-1, one per cycle: `RF_EN`=1, `WRITE`=0, `IDX`=c.
  - Data lanes hold their values.
  - After the last step the FSM moves to DRAIN.
- DRAIN:
  - `RF_EN`=0, `WRITE`=0.
  - Counts `DRAIN_CYCLES` cycles, then moves to FINISH.
- FINISH:
  - `DONE`=1 for exactly one cycle, then IDLE.
- ABORT:
  - Outside IDLE, `ABORT` takes priority over every other transition.
  - The next cycle the FSM is in IDLE with all outputs 0. No `DONE` is produced.
  - The next `START` reloads from `IDX`=0.
- `START` outside IDLE is ignored. This includes `START` asserted in the FINISH cycle.
- `IN_VALID` outside LOAD is ignored and causes no write.
- Width rules:
  - `IDX` is 5 bits. `COMPUTE_STEPS` must be ≤ 32 and `ROWS` ≤ 16; check both with elaboration-time assertions.
  - Counters are sized with `$clog2` of their maximum value plus 1. There is no wrap within a job.

## Timing
- Reset, while `RSTN`=0 (immediate, asynchronous):
  - State = IDLE.
  - `RF_EN`, `WRITE`, `IDX`, `X_DATA`, `W_DATA`, `BUSY`, `DONE` and `IN_READY` are all 0.
  - Counters are 0.
- Reset mid-operation abandons the job silently.
- `START` at cycle 0 gives LOAD, `BUSY`=1 and `IN_READY`=1 in cycle 1.
- A handshake at cycle n appears on the RF ports at cycle n+1.
- Let t be the cycle of the last handshake:
  - Last write on the ports: t+1.
  - Compute steps `IDX` 0..14: cycles t+2..t+16.
  - Drain: cycles t+17..t+24.
  - `DONE`=1: cycle t+25.
  - `BUSY` falls: cycle t+26.
- With back-to-back beats on cycles 1..8 (t=8), `DONE` is at cycle 33.

## Structure
- Shared package `sa_pkg`:
  - `DW`, `ROWS` and `IDX_W`=5.
  - State enum `rf_ld_state_e`.
  - Lane-slice helper function.
- `RF` consumes this package's lane layout.
- One sub-module, `sa_step_cnt`: a loadable up-counter with terminal-count flag.
  - Instantiate it for the row, compute-step and drain counters.

## Test plan
- Reset mid-COMPUTE:
  - Drop `RSTN` at `IDX`=5 → all outputs 0 in the same cycle.
  - After release, `IN_READY`=0 until `START`.
- Back-to-back job:
  - Stimulus: `START`, then 8 beats where row r lane k = X 0x1000+16r+k, W 0x2000+16r+k.
  - Response: WRITE pulses with `IDX` 0..7 and matching lanes; then `IDX` 0..14 with `WRITE`=0; `DONE` exactly at cycle 33.
- Bubbly load:
  - Stimulus: `IN_VALID` alternating 1/0.
  - Response: `RF_EN`=0 on bubble cycles; `IDX` 0..7 contiguous with no duplicate writes; `DONE` at t+25.
- ABORT after 3 beats:
  - Response: IDLE next cycle, `IN_READY`=0, no `DONE`.
  - A new `START` reloads starting at `IDX`=0.
- Ignored inputs:
  - `START` during COMPUTE and during the FINISH cycle → no restart, single `DONE`.
  - `IN_VALID` held high in IDLE/COMPUTE → `IN_READY`=0 and no writes.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared systolic-array constants, loader state encoding and RF lane helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sa_pkg;
    localparam int DW    = 16;
    localparam int ROWS  = 8;
    localparam int IDX_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_FINISH  = 3'd4
    } rf_ld_state_e;

    // Lane k of a packed row lives at bits [k*DW +: DW]; the RF relies on this layout.
    function automatic logic [DW-1:0] lane_get(input logic [ROWS*DW-1:0] row, input int unsigned k);
        return row[k*DW +: DW];
    endfunction
endpackage

// File: rtl/rf_loader_if.sv
// Row-in / RF-out bundle of the loader; master = upstream feeder, slave = loader.
// Latency: none (wiring only).
// Backpressure: IN_READY from the slave gates IN_VALID beats.
interface rf_loader_if #(
    parameter int DW   = sa_pkg::DW,
    parameter int ROWS = sa_pkg::ROWS
);
    logic                      START;
    logic                      ABORT;
    logic                      IN_VALID;
    logic                      IN_READY;
    logic [ROWS*DW-1:0]        IN_X;
    logic [ROWS*DW-1:0]        IN_W;
    logic                      RF_EN;
    logic                      WRITE;
    logic [sa_pkg::IDX_W-1:0]  IDX;
    logic [ROWS*DW-1:0]        X_DATA;
    logic [ROWS*DW-1:0]        W_DATA;
    logic                      BUSY;
    logic                      DONE;

    modport master (
        output START, ABORT, IN_VALID, IN_X, IN_W,
        input  IN_READY, RF_EN, WRITE, IDX, X_DATA, W_DATA, BUSY, DONE
    );

    modport slave (
        input  START, ABORT, IN_VALID, IN_X, IN_W,
        output IN_READY, RF_EN, WRITE, IDX, X_DATA, W_DATA, BUSY, DONE
    );
endinterface

// File: rtl/sa_step_cnt.sv
// Loadable up-counter with terminal-count flag; saturates at MAX-1 so it never wraps.
// Latency: load/increment visible one cycle later; tc is combinational from the count.
// Backpressure: none; en simply stalls the count.
module sa_step_cnt #(
    parameter  int MAX = 8,
    localparam int W   = $clog2(MAX) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

    // Load wins over increment; increment stops at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rf_loader.sv
// RF load/compute sequencer: loads ROWS rows, sweeps IDX for compute, drains, pulses DONE.
// Latency: a row beat reaches the RF ports one cycle after its handshake; DONE lands 25 cycles after the last beat.
// Backpressure: IN_READY is high only in LOAD; beats offered in any other state are dropped.
module rf_loader
    import sa_pkg::*;
#(
    parameter int DW            = sa_pkg::DW,
    parameter int ROWS          = sa_pkg::ROWS,
    parameter int COMPUTE_STEPS = 2 * ROWS - 1,
    parameter int DRAIN_CYCLES  = 8
) (
    input  logic        CLK,
    input  logic        RSTN,
    rf_loader_if.slave  bus
);
    localparam int ROW_W  = $clog2(ROWS) + 1;
    localparam int STEP_W = $clog2(COMPUTE_STEPS) + 1;
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1) + 1;

    if (COMPUTE_STEPS > 32) begin : g_chk_steps
        $error("rf_loader: COMPUTE_STEPS exceeds the 5-bit IDX range");
    end
    if (ROWS > 16) begin : g_chk_rows
        $error("rf_loader: ROWS must be 16 or fewer");
    end

    rf_ld_state_e state_q, state_d;

    logic                 rf_en_q, rf_en_d;
    logic                 write_q, write_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ROWS*DW-1:0]   x_data_q, x_data_d;
    logic [ROWS*DW-1:0]   w_data_q, w_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 hs;
    logic [ROW_W-1:0]     row_cnt;
    logic                 row_tc;
    logic [STEP_W-1:0]    step_cnt;
    logic                 step_tc;
    logic [DRN_W-1:0]     drain_cnt_unused;
    logic                 drain_tc;

    assign bus.IN_READY = (state_q == ST_LOAD);
    assign hs           = bus.IN_VALID && (state_q == ST_LOAD);

    // Row counter is held at zero through IDLE so every job starts writing at IDX 0.
    sa_step_cnt #(.MAX(ROWS)) u_row_cnt (
        .clk(CLK), .rst_n(RSTN), .load(state_q == ST_IDLE), .load_val('0),
        .en(hs), .cnt(row_cnt), .tc(row_tc)
    );

    sa_step_cnt #(.MAX(COMPUTE_STEPS)) u_step_cnt (
        .clk(CLK), .rst_n(RSTN), .load(state_q != ST_COMPUTE), .load_val('0),
        .en(state_q == ST_COMPUTE), .cnt(step_cnt), .tc(step_tc)
    );

    // The first DRAIN cycle still shows the last compute step on the ports, so the
    // state lingers DRAIN_CYCLES+1 cycles to give DRAIN_CYCLES idle port cycles.
    sa_step_cnt #(.MAX(DRAIN_CYCLES + 1)) u_drain_cnt (
        .clk(CLK), .rst_n(RSTN), .load(state_q != ST_DRAIN), .load_val('0),
        .en(state_q == ST_DRAIN), .cnt(drain_cnt_unused), .tc(drain_tc)
    );

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            rf_en_q  <= 1'b0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            x_data_q <= '0;
            w_data_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rf_en_q  <= rf_en_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            x_data_q <= x_data_d;
            w_data_q <= w_data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next state; ABORT pre-empts every transition outside IDLE.
    always_comb begin
        state_d = state_q;
        if (state_q != ST_IDLE && bus.ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (bus.START)    state_d = ST_LOAD;
                ST_LOAD:    if (hs && row_tc) state_d = ST_COMPUTE;
                ST_COMPUTE: if (step_tc)      state_d = ST_DRAIN;
                ST_DRAIN:   if (drain_tc)     state_d = ST_FINISH;
                ST_FINISH:                    state_d = ST_IDLE;
                default:                      state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the RF-facing outputs; BUSY/DONE track the state being entered.
    always_comb begin
        rf_en_d  = 1'b0;
        write_d  = write_q;
        idx_d    = idx_q;
        x_data_d = x_data_q;
        w_data_d = w_data_q;
        case (state_q)
            ST_LOAD: begin
                if (hs) begin
                    rf_en_d  = 1'b1;
                    write_d  = 1'b1;
                    idx_d    = IDX_W'(row_cnt);
                    x_data_d = bus.IN_X;
                    w_data_d = bus.IN_W;
                end
            end
            ST_COMPUTE: begin
                rf_en_d = 1'b1;
                write_d = 1'b0;
                idx_d   = IDX_W'(step_cnt);
            end
            ST_DRAIN: begin
                write_d = 1'b0;
            end
            default: begin
            end
        endcase
        if (state_d == ST_IDLE) begin
            rf_en_d  = 1'b0;
            write_d  = 1'b0;
            idx_d    = '0;
            x_data_d = '0;
            w_data_d = '0;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FINISH);
    end

    assign bus.RF_EN  = rf_en_q;
    assign bus.WRITE  = write_q;
    assign bus.IDX    = idx_q;
    assign bus.X_DATA = x_data_q;
    assign bus.W_DATA = w_data_q;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
endmodule

// File: tb/tb_rf_loader.sv
// Self-checking bench for rf_loader: scoreboard of expected RF events per job.
// Latency: model expects writes at handshake+1, compute at t+2..t+16, DONE at t+25.
// Backpressure: model mirrors IN_READY as "cycle >= 1 and fewer than ROWS rows taken".
`timescale 1ns/1ps
module tb_rf_loader;
    import sa_pkg::*;

    localparam int LW    = ROWS * DW;
    localparam int STEPS = 15;
    localparam int DRAIN = 8;

    typedef struct packed {
        logic             wr;
        logic [IDX_W-1:0] idx;
        logic [LW-1:0]    x;
        logic [LW-1:0]    w;
    } rf_ev_t;

    logic CLK  = 1'b0;
    logic RSTN = 1'b1;

    rf_loader_if #(.DW(DW), .ROWS(ROWS)) bus ();

    rf_loader #(.DW(DW), .ROWS(ROWS), .COMPUTE_STEPS(STEPS), .DRAIN_CYCLES(DRAIN)) dut (
        .CLK(CLK), .RSTN(RSTN), .bus(bus)
    );

    always #5 CLK = ~CLK;

    int     n_checks = 0;
    int     n_fail   = 0;
    rf_ev_t exp_q[$];

    function automatic logic [LW-1:0] mk_row(input logic [DW-1:0] base, input int r);
        logic [LW-1:0] v;
        v = '0;
        for (int k = 0; k < ROWS; k++) v[k*DW +: DW] = base + DW'(16 * r + k);
        return v;
    endfunction

    // Drive one cycle's inputs just after the rising edge, return at the falling edge.
    task automatic tick(input logic st, input logic ab, input logic iv,
                        input logic [LW-1:0] x, input logic [LW-1:0] w);
        @(posedge CLK);
        #1;
        bus.START = st; bus.ABORT = ab; bus.IN_VALID = iv; bus.IN_X = x; bus.IN_W = w;
        @(negedge CLK);
    endtask

    // One full job from START; checks every cycle against the scoreboard model.
    task automatic run_job(input bit bubbly, input bit noise, output int done_at, output int n_done);
        int            row = 0;
        int            t = -1;
        int            done_cyc = -1;
        bit            hs_prev = 1'b0;
        bit            hs;
        logic          st, iv, exp_ready, exp_en, exp_busy, exp_done;
        logic [LW-1:0] x, w;
        rf_ev_t        ev;
        done_at = -1;
        n_done  = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 120; cyc++) begin
            st = (cyc == 0) || (noise && t >= 0 && ((cyc >= t + 2 && cyc <= t + 10) || cyc == done_cyc));
            if (row < ROWS && cyc >= 1) iv = bubbly ? ((cyc % 2) == 1) : 1'b1;
            else                        iv = noise;
            if (row < ROWS) begin
                x = mk_row(16'h1000, row);
                w = mk_row(16'h2000, row);
            end else begin
                x = {$urandom(), $urandom(), $urandom(), $urandom()};
                w = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            tick(st, 1'b0, iv, x, w);
            exp_ready = (cyc >= 1) && (row < ROWS);
            exp_en    = hs_prev || (t >= 0 && cyc >= t + 2 && cyc <= t + STEPS + 1);
            exp_busy  = (cyc >= 1) && (t < 0 || cyc <= t + STEPS + DRAIN + 2);
            exp_done  = (t >= 0) && (cyc == t + STEPS + DRAIN + 2);
            n_checks++;
            if (bus.IN_READY !== exp_ready) begin
                n_fail++; $display("FAIL in_ready cyc %0d: got %0b want %0b", cyc, bus.IN_READY, exp_ready);
            end
            n_checks++;
            if (bus.RF_EN !== exp_en) begin
                n_fail++; $display("FAIL rf_en cyc %0d: got %0b want %0b", cyc, bus.RF_EN, exp_en);
            end
            n_checks++;
            if (bus.BUSY !== exp_busy) begin
                n_fail++; $display("FAIL busy cyc %0d: got %0b want %0b", cyc, bus.BUSY, exp_busy);
            end
            n_checks++;
            if (bus.DONE !== exp_done) begin
                n_fail++; $display("FAIL done cyc %0d: got %0b want %0b", cyc, bus.DONE, exp_done);
            end
            if (bus.DONE === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = cyc;
            end
            if (bus.RF_EN === 1'b1 && exp_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rf_event cyc %0d: got idx=%0d want no event", cyc, bus.IDX);
                end else begin
                    ev = exp_q.pop_front();
                    if (bus.WRITE !== ev.wr || bus.IDX !== ev.idx || bus.X_DATA !== ev.x || bus.W_DATA !== ev.w) begin
                        n_fail++;
                        $display("FAIL rf_event cyc %0d: got wr=%0b idx=%0d x=%h w=%h want wr=%0b idx=%0d x=%h w=%h",
                                 cyc, bus.WRITE, bus.IDX, bus.X_DATA, bus.W_DATA, ev.wr, ev.idx, ev.x, ev.w);
                    end
                end
            end
            hs      = iv && exp_ready;
            hs_prev = hs;
            if (hs) begin
                exp_q.push_back('{1'b1, IDX_W'(row), x, w});
                row++;
                if (row == ROWS) begin
                    t        = cyc;
                    done_cyc = t + STEPS + DRAIN + 2;
                    for (int c = 0; c < STEPS; c++) exp_q.push_back('{1'b0, IDX_W'(c), x, w});
                end
            end
            if (t >= 0 && cyc == done_cyc + 1) break;
        end
        n_checks++;
        if (done_at < 0) begin
            n_fail++; $display("FAIL job_timeout: got no DONE within 120 cycles want DONE");
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rf_events_left: got %0d unconsumed want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.IN_VALID = 1'b0; bus.IN_X = '0; bus.IN_W = '0;
        #2 RSTN = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({bus.RF_EN, bus.WRITE, bus.BUSY, bus.DONE, bus.IN_READY} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000", {bus.RF_EN, bus.WRITE, bus.BUSY, bus.DONE, bus.IN_READY});
        end
        n_checks++;
        if (bus.IDX !== '0 || bus.X_DATA !== '0 || bus.W_DATA !== '0) begin
            n_fail++; $display("FAIL reset_bus: got idx=%0d x=%h w=%h want 0", bus.IDX, bus.X_DATA, bus.W_DATA);
        end
        RSTN = 1'b1;
        tick(1'b0, 1'b0, 1'b1, mk_row(16'h1000, 0), mk_row(16'h2000, 0));
        tick(1'b0, 1'b0, 1'b1, mk_row(16'h1000, 0), mk_row(16'h2000, 0));
        n_checks++;
        if ({bus.IN_READY, bus.BUSY, bus.RF_EN} !== 3'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got rdy/busy/en=%b want 000", {bus.IN_READY, bus.BUSY, bus.RF_EN});
        end
    endtask

    task automatic test_back_to_back();
        int d, n;
        run_job(1'b0, 1'b0, d, n);
        n_checks++;
        if (d != 33 || n != 1) begin
            n_fail++; $display("FAIL b2b_done: got cycle %0d count %0d want cycle 33 count 1", d, n);
        end
    endtask

    task automatic test_bubbly();
        int d, n;
        run_job(1'b1, 1'b0, d, n);
        n_checks++;
        if (d != 40 || n != 1) begin
            n_fail++; $display("FAIL bubbly_done: got cycle %0d count %0d want cycle 40 count 1", d, n);
        end
    endtask

    task automatic test_abort();
        int d, n, dones;
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        for (int r = 0; r < 3; r++) tick(1'b0, 1'b0, 1'b1, mk_row(16'h1000, r), mk_row(16'h2000, r));
        tick(1'b0, 1'b1, 1'b1, mk_row(16'h1000, 3), mk_row(16'h2000, 3));
        n_checks++;
        if (bus.RF_EN !== 1'b1 || bus.IDX !== 5'd2 || bus.X_DATA !== mk_row(16'h1000, 2)) begin
            n_fail++; $display("FAIL abort_pre_write: got en=%0b idx=%0d want en=1 idx=2", bus.RF_EN, bus.IDX);
        end
        tick(1'b0, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if ({bus.BUSY, bus.IN_READY, bus.RF_EN, bus.WRITE} !== 4'b0 || bus.IDX !== '0 || bus.X_DATA !== '0 || bus.W_DATA !== '0) begin
            n_fail++; $display("FAIL abort_idle: got busy=%0b rdy=%0b en=%0b idx=%0d want all 0", bus.BUSY, bus.IN_READY, bus.RF_EN, bus.IDX);
        end
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0, 1'b0, '0, '0);
            if (bus.DONE === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d DONE pulses want 0", dones);
        end
        run_job(1'b0, 1'b0, d, n);
        n_checks++;
        if (d != 33 || n != 1) begin
            n_fail++; $display("FAIL restart_done: got cycle %0d count %0d want cycle 33 count 1", d, n);
        end
    endtask

    task automatic test_ignored();
        int d, n;
        run_job(1'b0, 1'b1, d, n);
        n_checks++;
        if (d != 33 || n != 1) begin
            n_fail++; $display("FAIL ignored_done: got cycle %0d count %0d want cycle 33 count 1", d, n);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b1, mk_row(16'h3000, i), mk_row(16'h4000, i));
            n_checks++;
            if ({bus.IN_READY, bus.BUSY, bus.RF_EN, bus.DONE} !== 4'b0) begin
                n_fail++; $display("FAIL ignored_idle %0d: got rdy/busy/en/done=%b want 0000", i, {bus.IN_READY, bus.BUSY, bus.RF_EN, bus.DONE});
            end
        end
    endtask

    task automatic test_reset_mid_compute();
        bit found;
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        for (int r = 0; r < ROWS; r++) tick(1'b0, 1'b0, 1'b1, mk_row(16'h1000, r), mk_row(16'h2000, r));
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1'b0, 1'b0, 1'b0, '0, '0);
            if (bus.RF_EN === 1'b1 && bus.WRITE === 1'b0 && bus.IDX === 5'd5) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL mid_compute_reach: got no IDX=5 compute step want one");
        end else begin
            #2 RSTN = 1'b0;
            #1;
            n_checks++;
            if ({bus.RF_EN, bus.WRITE, bus.BUSY, bus.DONE, bus.IN_READY} !== 5'b0 || bus.IDX !== '0 || bus.X_DATA !== '0 || bus.W_DATA !== '0) begin
                n_fail++; $display("FAIL async_reset: got en=%0b wr=%0b busy=%0b idx=%0d want all 0", bus.RF_EN, bus.WRITE, bus.BUSY, bus.IDX);
            end
            @(negedge CLK);
            RSTN = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick(1'b0, 1'b0, 1'b1, mk_row(16'h1000, i), mk_row(16'h2000, i));
                n_checks++;
                if ({bus.IN_READY, bus.BUSY, bus.RF_EN} !== 3'b0) begin
                    n_fail++; $display("FAIL post_reset_idle %0d: got rdy/busy/en=%b want 000", i, {bus.IN_READY, bus.BUSY, bus.RF_EN});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbly();
        test_abort();
        test_ignored();
        test_reset_mid_compute();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end
endmodule
